// File: rtl/ex_mem_wb_pipe_if.sv
// EX/MEM/WB pipeline signal bundle: EX-stage instruction, forwarding selects,
// hazard inputs, and the forwarded/registered outputs back to the core.
interface ex_mem_wb_pipe_if;
  logic        i_ex_valid;
  logic        i_ex_rd_wren;
  logic        i_ex_is_load;
  logic [4:0]  i_ex_rd_addr;
  logic [31:0] i_ex_alu_result;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic [1:0]  i_rs1_fwd_flags;
  logic [1:0]  i_rs2_fwd_flags;
  logic [4:0]  i_id_rs1_addr;
  logic [4:0]  i_id_rs2_addr;
  logic        i_id_rs1_valid;
  logic        i_id_rs2_valid;
  logic [31:0] i_mem_load_data;
  logic        i_hold;
  logic        i_flush;

  logic [31:0] o_rs1_fwd_data;
  logic [31:0] o_rs2_fwd_data;
  logic [4:0]  o_mem_rd_addr;
  logic        o_mem_fwd_allow;
  logic [31:0] o_mem_fwd_data;
  logic        o_mem_is_load;
  logic [31:0] o_mem_store_data;
  logic [4:0]  o_wb_rd_addr;
  logic        o_wb_wren;
  logic        o_wb_fwd_allow;
  logic [31:0] o_wb_data;
  logic        o_idex_bubble;
  logic        o_id_stall;
  logic [15:0] o_stall_cnt;

  modport master (
    output i_ex_valid, i_ex_rd_wren, i_ex_is_load, i_ex_rd_addr, i_ex_alu_result,
           i_rs1_data, i_rs2_data, i_rs1_fwd_flags, i_rs2_fwd_flags,
           i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_valid, i_id_rs2_valid,
           i_mem_load_data, i_hold, i_flush,
    input  o_rs1_fwd_data, o_rs2_fwd_data, o_mem_rd_addr, o_mem_fwd_allow,
           o_mem_fwd_data, o_mem_is_load, o_mem_store_data, o_wb_rd_addr,
           o_wb_wren, o_wb_fwd_allow, o_wb_data, o_idex_bubble, o_id_stall,
           o_stall_cnt
  );

  modport slave (
    input  i_ex_valid, i_ex_rd_wren, i_ex_is_load, i_ex_rd_addr, i_ex_alu_result,
           i_rs1_data, i_rs2_data, i_rs1_fwd_flags, i_rs2_fwd_flags,
           i_id_rs1_addr, i_id_rs2_addr, i_id_rs1_valid, i_id_rs2_valid,
           i_mem_load_data, i_hold, i_flush,
    output o_rs1_fwd_data, o_rs2_fwd_data, o_mem_rd_addr, o_mem_fwd_allow,
           o_mem_fwd_data, o_mem_is_load, o_mem_store_data, o_wb_rd_addr,
           o_wb_wren, o_wb_fwd_allow, o_wb_data, o_idex_bubble, o_id_stall,
           o_stall_cnt
  );
endinterface

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with operand forwarding, load-use
// bubble detection and a saturating bubble counter.
module ex_mem_wb_pipe (
  input  logic              i_clk,
  input  logic              i_rst,
  ex_mem_wb_pipe_if.slave   bus
);

  logic        mem_valid;
  logic        mem_rd_wren;
  logic        mem_is_load;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_store_data;

  logic        wb_valid;
  logic        wb_wren;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;

  logic [15:0] stall_cnt;
  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;
  logic        rs1_hit;
  logic        rs2_hit;
  logic        bubble;

  // Illegal 11 select falls back to the MEM value, the youngest producer.
  function automatic logic [31:0] fwd_sel(input logic [1:0]  flags,
                                          input logic [31:0] reg_data,
                                          input logic [31:0] mem_data,
                                          input logic [31:0] wbk_data);
    case (flags)
      2'b00:   fwd_sel = reg_data;
      2'b10:   fwd_sel = wbk_data;
      default: fwd_sel = mem_data;
    endcase
  endfunction

  always_comb begin
    rs1_fwd = fwd_sel(bus.i_rs1_fwd_flags, bus.i_rs1_data, mem_alu_result, wb_data);
    rs2_fwd = fwd_sel(bus.i_rs2_fwd_flags, bus.i_rs2_data, mem_alu_result, wb_data);
    rs1_hit = bus.i_id_rs1_valid && (bus.i_id_rs1_addr == bus.i_ex_rd_addr);
    rs2_hit = bus.i_id_rs2_valid && (bus.i_id_rs2_addr == bus.i_ex_rd_addr);
    bubble  = bus.i_ex_valid && bus.i_ex_is_load && bus.i_ex_rd_wren &&
              (bus.i_ex_rd_addr != 5'd0) && !bus.i_flush && (rs1_hit || rs2_hit);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_valid      <= 1'b0;
      mem_rd_wren    <= 1'b0;
      mem_is_load    <= 1'b0;
      mem_rd_addr    <= 5'd0;
      mem_alu_result <= 32'd0;
      mem_store_data <= 32'd0;
      wb_valid       <= 1'b0;
      wb_wren        <= 1'b0;
      wb_rd_addr     <= 5'd0;
      wb_data        <= 32'd0;
      stall_cnt      <= 16'd0;
    end else if (!bus.i_hold) begin
      mem_valid      <= bus.i_ex_valid & ~bus.i_flush;
      mem_rd_wren    <= bus.i_ex_rd_wren;
      mem_is_load    <= bus.i_ex_is_load;
      mem_rd_addr    <= bus.i_ex_rd_addr;
      mem_alu_result <= bus.i_ex_alu_result;
      mem_store_data <= rs2_fwd;
      wb_valid       <= mem_valid;
      wb_wren        <= mem_valid & mem_rd_wren;
      wb_rd_addr     <= mem_rd_addr;
      wb_data        <= mem_is_load ? bus.i_mem_load_data : mem_alu_result;
      if (bubble && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.o_rs1_fwd_data   = rs1_fwd;
  assign bus.o_rs2_fwd_data   = rs2_fwd;
  assign bus.o_mem_rd_addr    = mem_rd_addr;
  assign bus.o_mem_fwd_allow  = mem_valid & mem_rd_wren & (mem_rd_addr != 5'd0) & ~mem_is_load;
  assign bus.o_mem_fwd_data   = mem_alu_result;
  assign bus.o_mem_is_load    = mem_valid & mem_is_load;
  assign bus.o_mem_store_data = mem_store_data;
  assign bus.o_wb_rd_addr     = wb_rd_addr;
  assign bus.o_wb_wren        = wb_valid & wb_wren;
  assign bus.o_wb_fwd_allow   = wb_valid & wb_wren & (wb_rd_addr != 5'd0);
  assign bus.o_wb_data        = wb_data;
  assign bus.o_idex_bubble    = bubble;
  assign bus.o_id_stall       = bubble | bus.i_hold;
  assign bus.o_stall_cnt      = stall_cnt;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Directed bench for ex_mem_wb_pipe: per-cycle vector table plus hold,
// reset-during-hold and counter saturation sequences.
module tb_ex_mem_wb_pipe;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_mem_wb_pipe_if bus ();

  ex_mem_wb_pipe dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        ex_valid, wren, is_load;
    logic [4:0]  rd;
    logic [31:0] alu, rs1d, rs2d;
    logic [1:0]  f1, f2;
    logic [4:0]  id1;
    logic        id1v;
    logic [4:0]  id2;
    logic        id2v;
    logic [31:0] ld;
    logic        hold, flush;
    logic [31:0] e_rs1, e_rs2;
    logic        e_bub;
    logic        e_mallow;
    logic [31:0] e_mdata;
    logic        e_mload;
    logic [31:0] e_store;
    logic        e_wwren, e_wallow;
    logic [31:0] e_wdata;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_ex_valid      = v.ex_valid;
    bus.i_ex_rd_wren    = v.wren;
    bus.i_ex_is_load    = v.is_load;
    bus.i_ex_rd_addr    = v.rd;
    bus.i_ex_alu_result = v.alu;
    bus.i_rs1_data      = v.rs1d;
    bus.i_rs2_data      = v.rs2d;
    bus.i_rs1_fwd_flags = v.f1;
    bus.i_rs2_fwd_flags = v.f2;
    bus.i_id_rs1_addr   = v.id1;
    bus.i_id_rs1_valid  = v.id1v;
    bus.i_id_rs2_addr   = v.id2;
    bus.i_id_rs2_valid  = v.id2v;
    bus.i_mem_load_data = v.ld;
    bus.i_hold          = v.hold;
    bus.i_flush         = v.flush;
  endtask

  task automatic chk_regs(input string tag, input logic mallow, input logic [31:0] mdata,
                          input logic mload, input logic [31:0] store, input logic wwren,
                          input logic wallow, input logic [31:0] wdata, input logic [15:0] cnt);
    chk({tag, " mem_fwd_allow"},  32'(bus.o_mem_fwd_allow), 32'(mallow));
    chk({tag, " mem_fwd_data"},   bus.o_mem_fwd_data, mdata);
    chk({tag, " mem_is_load"},    32'(bus.o_mem_is_load), 32'(mload));
    chk({tag, " mem_store_data"}, bus.o_mem_store_data, store);
    chk({tag, " wb_wren"},        32'(bus.o_wb_wren), 32'(wwren));
    chk({tag, " wb_fwd_allow"},   32'(bus.o_wb_fwd_allow), 32'(wallow));
    chk({tag, " wb_data"},        bus.o_wb_data, wdata);
    chk({tag, " stall_cnt"},      32'(bus.o_stall_cnt), 32'(cnt));
  endtask

  vec_t z;
  vec_t s;

  initial begin
    z = '{1'b0,1'b0,1'b0,5'd0,32'h0, 32'h0,32'h0, 2'b00,2'b00, 5'd0,1'b0,5'd0,1'b0, 32'h0, 1'b0,1'b0,
          32'h0,32'h0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0,32'h0, 16'd0};
    // ALU chain x5 = 0x10, consumer forwards from MEM then WB
    vec[0] = '{1'b1,1'b1,1'b0,5'd5,32'h10, 32'h111,32'h222, 2'b00,2'b00, 5'd0,1'b0,5'd0,1'b0, 32'h0, 1'b0,1'b0,
               32'h111,32'h222,1'b0, 1'b1,32'h10,1'b0,32'h222, 1'b0,1'b0,32'h0, 16'd0};
    vec[1] = '{1'b1,1'b1,1'b0,5'd6,32'h20, 32'hAAA,32'h333, 2'b01,2'b00, 5'd0,1'b0,5'd0,1'b0, 32'h0, 1'b0,1'b0,
               32'h10,32'h333,1'b0, 1'b1,32'h20,1'b0,32'h333, 1'b1,1'b1,32'h10, 16'd0};
    // lw x7 with ID reading x7 on rs2; WB select on rs1, illegal 11 on rs2
    vec[2] = '{1'b1,1'b1,1'b1,5'd7,32'h100, 32'h0,32'h0, 2'b10,2'b11, 5'd3,1'b1,5'd7,1'b1, 32'h0, 1'b0,1'b0,
               32'h10,32'h20,1'b1, 1'b0,32'h100,1'b1,32'h20, 1'b1,1'b1,32'h20, 16'd1};
    vec[3] = '{1'b0,1'b0,1'b0,5'd0,32'h0, 32'h44,32'h55, 2'b00,2'b00, 5'd0,1'b0,5'd0,1'b0, 32'hCAFE, 1'b0,1'b0,
               32'h44,32'h55,1'b0, 1'b0,32'h0,1'b0,32'h55, 1'b1,1'b1,32'hCAFE, 16'd1};
    // x0 destinations
    vec[4] = '{1'b1,1'b1,1'b0,5'd0,32'h55, 32'h0,32'h0, 2'b00,2'b00, 5'd0,1'b0,5'd0,1'b0, 32'h0, 1'b0,1'b0,
               32'h0,32'h0,1'b0, 1'b0,32'h55,1'b0,32'h0, 1'b0,1'b0,32'h0, 16'd1};
    vec[5] = '{1'b1,1'b1,1'b1,5'd0,32'h200, 32'h0,32'h0, 2'b00,2'b00, 5'd0,1'b1,5'd0,1'b0, 32'h0, 1'b0,1'b0,
               32'h0,32'h0,1'b0, 1'b0,32'h200,1'b1,32'h0, 1'b1,1'b0,32'h55, 16'd1};
    // flush kills EX; the load already in MEM retires
    vec[6] = '{1'b1,1'b1,1'b0,5'd9,32'h99, 32'h0,32'h0, 2'b00,2'b00, 5'd9,1'b1,5'd0,1'b0, 32'h777, 1'b0,1'b1,
               32'h0,32'h0,1'b0, 1'b0,32'h99,1'b0,32'h0, 1'b1,1'b0,32'h777, 16'd1};
    vec[7] = '{1'b0,1'b0,1'b0,5'd0,32'h0, 32'h0,32'h0, 2'b01,2'b00, 5'd0,1'b0,5'd0,1'b0, 32'h5A5A, 1'b0,1'b0,
               32'h99,32'h0,1'b0, 1'b0,32'h0,1'b0,32'h0, 1'b0,1'b0,32'h99, 16'd1};

    drive(z);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(vec[i]);
      #1;
      chk($sformatf("v%0d rs1_fwd", i), bus.o_rs1_fwd_data, vec[i].e_rs1);
      chk($sformatf("v%0d rs2_fwd", i), bus.o_rs2_fwd_data, vec[i].e_rs2);
      chk($sformatf("v%0d idex_bubble", i), 32'(bus.o_idex_bubble), 32'(vec[i].e_bub));
      chk($sformatf("v%0d id_stall", i), 32'(bus.o_id_stall), 32'(vec[i].e_bub | vec[i].hold));
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", i), vec[i].e_mallow, vec[i].e_mdata, vec[i].e_mload,
               vec[i].e_store, vec[i].e_wwren, vec[i].e_wallow, vec[i].e_wdata, vec[i].e_cnt);
      @(negedge clk);
    end

    // Fill both stages: x3 = 0x33 then x4 = 0x44
    s = z; s.ex_valid = 1'b1; s.wren = 1'b1; s.rd = 5'd3; s.alu = 32'h33; s.rs2d = 32'hB0B;
    drive(s);
    @(negedge clk);
    s.rd = 5'd4; s.alu = 32'h44; s.rs2d = 32'hC0C;
    drive(s);
    @(negedge clk);

    // Hold three cycles with a load-use pending in EX
    s = z; s.ex_valid = 1'b1; s.wren = 1'b1; s.is_load = 1'b1; s.rd = 5'd8; s.alu = 32'h888;
    s.id1 = 5'd8; s.id1v = 1'b1; s.ld = 32'hDEAD; s.hold = 1'b1; s.rs2d = 32'h1234;
    drive(s);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d idex_bubble", c), 32'(bus.o_idex_bubble), 32'd1);
      chk($sformatf("hold%0d id_stall", c), 32'(bus.o_id_stall), 32'd1);
      @(posedge clk);
      #1;
      chk_regs($sformatf("hold%0d", c), 1'b1, 32'h44, 1'b0, 32'hC0C, 1'b1, 1'b1, 32'h33, 16'd1);
      chk($sformatf("hold%0d mem_rd_addr", c), 32'(bus.o_mem_rd_addr), 32'd4);
      chk($sformatf("hold%0d wb_rd_addr", c), 32'(bus.o_wb_rd_addr), 32'd3);
      @(negedge clk);
    end

    // Reset while still held discards everything
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_regs("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0);
    chk("rst_hold mem_rd_addr", 32'(bus.o_mem_rd_addr), 32'd0);
    chk("rst_hold wb_rd_addr", 32'(bus.o_wb_rd_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s = z; s.f1 = 2'b01; s.f2 = 2'b10; s.rs1d = 32'hFFFF_0001; s.rs2d = 32'hFFFF_0002;
    drive(s);
    #1;
    chk("post_rst rs1_fwd", bus.o_rs1_fwd_data, 32'h0);
    chk("post_rst rs2_fwd", bus.o_rs2_fwd_data, 32'h0);
    @(posedge clk);
    #1;
    chk_regs("post_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 16'd0);
    @(negedge clk);

    // Drive the bubble counter into saturation
    s = z; s.ex_valid = 1'b1; s.wren = 1'b1; s.is_load = 1'b1; s.rd = 5'd7; s.alu = 32'h40;
    s.id2 = 5'd7; s.id2v = 1'b1;
    drive(s);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat pre stall_cnt", 32'(bus.o_stall_cnt), 32'hFFFE);
    @(posedge clk);
    #1;
    chk("sat reach stall_cnt", 32'(bus.o_stall_cnt), 32'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat hold stall_cnt", 32'(bus.o_stall_cnt), 32'hFFFF);
    chk("sat idex_bubble", 32'(bus.o_idex_bubble), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_pipe.md
EX_MEM_WB_PIPE -- requirements
Module: ex_mem_wb_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: i_clk drives all state; i_rst, when high at a rising edge, resets all state.
REQ-002 i_clk  in  1  clock; all state updates on the rising edge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_ex_valid, i_ex_rd_wren, i_ex_is_load  in  1 each  describe the EX-stage instruction: valid, writes rd, is a load.
REQ-005 i_ex_rd_addr  in  5  EX-stage destination register.
REQ-006 i_ex_alu_result  in  32  EX-stage ALU result or load address.
REQ-007 i_rs1_data, i_rs2_data  in  32 each  register-file operands held in the ID/EX buffer.
REQ-008 i_rs1_fwd_flags, i_rs2_fwd_flags  in  2 each  one-hot forwarding selects: bit0 = MEM, bit1 = WB.
REQ-009 i_id_rs1_addr, i_id_rs2_addr  in  5 each; i_id_rs1_valid, i_id_rs2_valid  in  1 each  ID-stage source registers.
REQ-010 i_mem_load_data  in  32  load data, valid in the cycle the load occupies MEM.
REQ-011 i_hold  in  1  downstream memory stall; i_flush  in  1  kills the EX-stage instruction.
REQ-012 o_rs1_fwd_data, o_rs2_fwd_data  out  32 each  forwarded operands to the ALU (combinational).
REQ-013 o_mem_rd_addr  out  5; o_mem_fwd_allow  out  1; o_mem_fwd_data  out  32; o_mem_is_load  out  1; o_mem_store_data  out  32  EX/MEM register contents.
REQ-014 o_wb_rd_addr  out  5; o_wb_wren  out  1; o_wb_fwd_allow  out  1; o_wb_data  out  32  MEM/WB register contents.
REQ-015 o_idex_bubble, o_id_stall  out  1 each  load-use hazard and stall controls; o_stall_cnt  out  16  load-use bubble counter.

Function
REQ-016 Operand select SHALL be: flags 01 -> o_mem_fwd_data; 10 -> o_wb_data; 00 -> i_rsX_data; 11 (illegal) -> o_mem_fwd_data.
REQ-017 EX/MEM SHALL capture on every edge with i_hold low: mem_valid = i_ex_valid & ~i_flush, plus rd_addr, rd_wren, is_load, alu_result (-> o_mem_fwd_data) and o_rs2_fwd_data (-> o_mem_store_data).
REQ-018 MEM/WB SHALL capture on every edge with i_hold low: wb_valid = mem_valid, rd_addr, wren = mem_valid & mem_rd_wren, and o_wb_data = mem_is_load ? i_mem_load_data : mem alu_result.
REQ-019 With i_hold high, both registers and o_stall_cnt SHALL hold their values. i_hold has priority over i_flush.
REQ-020 o_mem_fwd_allow SHALL equal mem_valid & mem_rd_wren & (mem_rd_addr != 0) & ~mem_is_load. Load data is never forwarded from MEM.
REQ-021 o_wb_fwd_allow SHALL equal o_wb_wren & (o_wb_rd_addr != 0).
REQ-022 o_mem_is_load SHALL equal mem_valid & mem_is_load.
REQ-023 o_idex_bubble SHALL be combinational and equal i_ex_valid & i_ex_is_load & i_ex_rd_wren & (i_ex_rd_addr != 0) & ~i_flush & ((i_id_rs1_valid & rs1 match) | (i_id_rs2_valid & rs2 match)).
REQ-024 o_id_stall SHALL equal o_idex_bubble | i_hold.
REQ-025 o_stall_cnt SHALL increment by 1 on each edge where o_idex_bubble = 1 and i_hold = 0, and SHALL saturate at 0xFFFF.
REQ-026 Latency SHALL be one cycle EX -> MEM and one cycle MEM -> WB. A load result becomes forwardable from WB exactly one cycle after the load leaves MEM.

Reset
REQ-027 While i_rst is high, all valid, wren and is_load bits, all rd_addr and data registers, and o_stall_cnt SHALL clear to 0 at the edge. Reset has priority over i_hold and i_flush.
REQ-028 After reset, o_mem_fwd_allow = o_wb_fwd_allow = 0 and o_mem_fwd_data = o_wb_data = 0. The combinational outputs follow their inputs.
REQ-029 A reset asserted mid-stall SHALL discard the in-flight instructions with no stale forwarding on the first cycle after release.

Verification
REQ-030 ALU chain: EX add x5 = 0x10, then the next instruction reads x5 with rs1_flags = 01 -> o_rs1_fwd_data = 0x10; the following cycle o_wb_fwd_allow = 1, o_wb_data = 0x10.
REQ-031 Load-use: EX lw x7, ID reads x7 on rs2 -> o_idex_bubble = 1, o_id_stall = 1, o_stall_cnt 0 -> 1; the next cycle o_mem_fwd_allow = 0; load data 0xCAFE appears on o_wb_data one cycle later.
REQ-032 x0 destination: EX writes x0 with result 0x55 -> o_mem_fwd_allow = 0 and o_wb_fwd_allow = 0; EX lw x0 with ID reading x0 -> o_idex_bubble = 0.
REQ-033 i_hold = 1 for 3 cycles with both registers full -> all outputs are unchanged; o_id_stall = 1 throughout; the load-use counter does not increment.
REQ-034 i_flush with a valid EX instruction -> the next cycle mem_valid = 0 and o_mem_fwd_allow = 0; the instruction already in MEM retires normally to WB.
REQ-035 Saturation and reset: preload o_stall_cnt to 0xFFFF via repeated load-use -> it stays at 0xFFFF; asserting i_rst during i_hold -> all registers are 0 at the next edge.
